// File: rtl/pyseq_ctrl_pkg.sv
// Shared definitions for the payload sequencer: packet types, FSM states,
// symbol-rate divider values and the packet-type configuration decoder.
package pyseq_ctrl_pkg;

  localparam logic [3:0] PT_NULL = 4'h0;
  localparam logic [3:0] PT_POLL = 4'h1;
  localparam logic [3:0] PT_FHS  = 4'h2;
  localparam logic [3:0] PT_DM1  = 4'h3;
  localparam logic [3:0] PT_DH1  = 4'h4;
  localparam logic [3:0] PT_HV1  = 4'h5;
  localparam logic [3:0] PT_HV2  = 4'h6;
  localparam logic [3:0] PT_HV3  = 4'h7;
  localparam logic [3:0] PT_DV   = 4'h8;
  localparam logic [3:0] PT_AUX1 = 4'h9;
  localparam logic [3:0] PT_DM3  = 4'hA;
  localparam logic [3:0] PT_DH3  = 4'hB;
  localparam logic [3:0] PT_DM5  = 4'hE;
  localparam logic [3:0] PT_DH5  = 4'hF;

  localparam logic [2:0] DIV_BR   = 3'd6;
  localparam logic [2:0] DIV_DPSK = 3'd3;
  localparam logic [2:0] DIV_8PSK = 3'd2;

  localparam logic [9:0] MAX_LEN_BYTE = 10'd1021;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_RUN,
    S_TAIL,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic        ok;
    logic [12:0] len_bits;
    logic        crc;
    logic        fec31;
    logic        fec32;
  } pycfg_t;

  function automatic pycfg_t decode_type(input logic [3:0] ptype, input logic [9:0] len_byte);
    pycfg_t     c;
    logic [9:0] lb;
    lb = (len_byte > MAX_LEN_BYTE) ? MAX_LEN_BYTE : len_byte;
    c = '0;
    c.ok = 1'b1;
    case (ptype)
      PT_NULL, PT_POLL: begin end
      PT_FHS:                begin c.len_bits = 13'd144; c.crc = 1'b1; c.fec32 = 1'b1; end
      PT_DM1, PT_DM3, PT_DM5: begin c.len_bits = {lb, 3'b000}; c.crc = 1'b1; c.fec32 = 1'b1; end
      PT_DH1, PT_DH3, PT_DH5: begin c.len_bits = {lb, 3'b000}; c.crc = 1'b1; end
      PT_HV1:                begin c.len_bits = 13'd80;  c.fec31 = 1'b1; end
      PT_HV2:                begin c.len_bits = 13'd160; c.fec32 = 1'b1; end
      PT_HV3:                c.len_bits = 13'd240;
      PT_AUX1:               c.len_bits = {lb, 3'b000};
      default:               c.ok = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pyseq_ctrl_pysym_strobe.sv
// Symbol-rate divider: counts 0..n-1 while enabled and strobes on the last count.
module pysym_strobe (
  input  logic       clk_6M,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [2:0] n,
  output logic       py_datvalid_p
);

  logic [2:0] cnt;
  logic       at_top;

  assign at_top = (cnt == n - 3'd1);

  always_ff @(posedge clk_6M) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_top ? '0 : cnt + 3'd1;
    end
  end

  assign py_datvalid_p = en && at_top;

endmodule

// File: rtl/pyseq_ctrl.sv
// Payload sequencer: latches packet configuration on start, paces symbols,
// and waits for end-of-payload (and EDR tailer on transmit) before completing.
module pyseq_ctrl
  import pyseq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_SYM = 8191
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        start_p,
  input  logic        abort_p,
  input  logic        tx,
  input  logic [3:0]  pk_type,
  input  logic [9:0]  len_byte,
  input  logic        packet_BRmode,
  input  logic        packet_DPSK,
  input  logic        py_endp,
  input  logic        dec_py_endp,
  input  logic        edrtailer_endp,
  output logic        py_st_p,
  output logic        py_datvalid_p,
  output logic [12:0] pylenbit,
  output logic        crcencode,
  output logic        fec31encode,
  output logic        fec32encode,
  output logic        pk_encode,
  output logic        busy,
  output logic        done_p,
  output logic        err_p
);

  localparam int CW = $clog2(TIMEOUT_SYM + 1);

  state_t        state, state_nx;
  pycfg_t        cfg_in;
  logic          br_q;
  logic [2:0]    div_n;
  logic [CW-1:0] sym_cnt;
  logic          run_en, strobe_clr, accept, end_ev;

  assign cfg_in     = decode_type(pk_type, len_byte);
  assign accept     = (state == S_IDLE) && start_p && !abort_p;
  assign run_en     = (state == S_RUN) || (state == S_TAIL);
  assign strobe_clr = !run_en;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state       <= S_IDLE;
      pylenbit    <= '0;
      crcencode   <= 1'b0;
      fec31encode <= 1'b0;
      fec32encode <= 1'b0;
      pk_encode   <= 1'b0;
      br_q        <= 1'b0;
      div_n       <= DIV_BR;
      sym_cnt     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        pylenbit    <= cfg_in.len_bits;
        crcencode   <= cfg_in.crc;
        fec31encode <= cfg_in.fec31;
        fec32encode <= cfg_in.fec32;
        pk_encode   <= tx;
        br_q        <= packet_BRmode;
        div_n       <= packet_BRmode ? DIV_BR : (packet_DPSK ? DIV_DPSK : DIV_8PSK);
      end
      if (state == S_ST) begin
        sym_cnt <= '0;
      end else if (py_datvalid_p) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    py_st_p  = 1'b0;
    done_p   = 1'b0;
    err_p    = 1'b0;
    end_ev   = pk_encode ? py_endp : dec_py_endp;
    case (state)
      S_IDLE: if (start_p) state_nx = cfg_in.ok ? S_ST : S_ERR;
      S_ST: begin
        py_st_p  = 1'b1;
        state_nx = (pylenbit == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (end_ev) state_nx = (pk_encode && !br_q) ? S_TAIL : S_DONE;
        else if (sym_cnt == CW'(TIMEOUT_SYM)) state_nx = S_ERR;
      end
      S_TAIL: if (edrtailer_endp) state_nx = S_DONE;
      S_DONE: begin
        done_p   = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        err_p    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides every transition, including a coincident end event.
    if (abort_p) state_nx = S_IDLE;
  end

  pysym_strobe u_strobe (
    .clk_6M        (clk_6M),
    .rst           (rst),
    .clr           (strobe_clr),
    .en            (run_en),
    .n             (div_n),
    .py_datvalid_p (py_datvalid_p)
  );

endmodule

// File: tb/tb_pyseq_ctrl.sv
// Scoreboard bench for pyseq_ctrl: expected pulse events (cycle, kind) are queued
// as stimulus is driven and matched against pulses observed on the falling edge.
module tb_pyseq_ctrl;

  logic        clk_6M = 1'b0;
  logic        rst = 1'b1;
  logic        start_p = 1'b0, abort_p = 1'b0, tx = 1'b0;
  logic [3:0]  pk_type = '0;
  logic [9:0]  len_byte = '0;
  logic        packet_BRmode = 1'b0, packet_DPSK = 1'b0;
  logic        py_endp = 1'b0, dec_py_endp = 1'b0, edrtailer_endp = 1'b0;
  logic        py_st_p, py_datvalid_p, crcencode, fec31encode, fec32encode;
  logic        pk_encode, busy, done_p, err_p;
  logic [12:0] pylenbit;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  logic [3:0] mon_ev;

  pyseq_ctrl #(.TIMEOUT_SYM(8191)) dut (
    .clk_6M(clk_6M), .rst(rst), .start_p(start_p), .abort_p(abort_p), .tx(tx),
    .pk_type(pk_type), .len_byte(len_byte), .packet_BRmode(packet_BRmode),
    .packet_DPSK(packet_DPSK), .py_endp(py_endp), .dec_py_endp(dec_py_endp),
    .edrtailer_endp(edrtailer_endp), .py_st_p(py_st_p), .py_datvalid_p(py_datvalid_p),
    .pylenbit(pylenbit), .crcencode(crcencode), .fec31encode(fec31encode),
    .fec32encode(fec32encode), .pk_encode(pk_encode), .busy(busy),
    .done_p(done_p), .err_p(err_p)
  );

  always #5 clk_6M = ~clk_6M;
  always @(posedge clk_6M) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Event code = cycle*4 + kind (0 st, 1 datvalid, 2 done, 3 err).
  task automatic push_ev(input int c, input int k);
    exp_q.push_back(c * 4 + k);
  endtask

  always @(negedge clk_6M) begin
    mon_ev = {err_p, done_p, py_datvalid_p, py_st_p};
    for (int k = 0; k < 4; k++) begin
      if (mon_ev[k]) begin
        if (exp_q.size() == 0) check_val("unexpected_event", cyc * 4 + k, -1);
        else check_val("event", cyc * 4 + k, exp_q.pop_front());
      end
    end
  end

  task automatic next();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next();
  endtask

  task automatic run_pkt(input logic t_tx, input logic [3:0] t_type, input logic [9:0] t_len,
                         input logic t_br, input logic t_dpsk, input int want_len,
                         input int want_crc, input int want_f31, input int want_f32,
                         input int n, input int end_off, input int tail_off);
    int t0, e, last;
    next();
    t0 = cyc;
    tx = t_tx; pk_type = t_type; len_byte = t_len;
    packet_BRmode = t_br; packet_DPSK = t_dpsk; start_p = 1'b1;
    push_ev(t0 + 1, 0);
    e = t0 + end_off;
    if (want_len == 0) last = t0 + 1;
    else begin
      last = (tail_off != 0) ? e + tail_off : e;
      for (int c = t0 + n + 1; c <= last; c += n) push_ev(c, 1);
    end
    push_ev(last + 1, 2);
    next();
    start_p = 1'b0;
    check_val("pylenbit", int'(pylenbit), want_len);
    check_val("crcencode", int'(crcencode), want_crc);
    check_val("fec31encode", int'(fec31encode), want_f31);
    check_val("fec32encode", int'(fec32encode), want_f32);
    check_val("pk_encode", int'(pk_encode), int'(t_tx));
    if (want_len != 0) begin
      wait_until(e);
      if (t_tx) py_endp = 1'b1; else dec_py_endp = 1'b1;
      next();
      py_endp = 1'b0; dec_py_endp = 1'b0;
      if (tail_off != 0) begin
        wait_until(last);
        edrtailer_endp = 1'b1;
        next();
        edrtailer_endp = 1'b0;
      end
    end
    wait_until(last + 1);
    check_val("busy_in_done", int'(busy), 1);
    next();
    check_val("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    next(); next(); next();
    check_val("rst_outputs", int'({py_st_p, py_datvalid_p, done_p, err_p, busy}), 0);
    check_val("rst_pylenbit", int'(pylenbit), 0);
    check_val("rst_config", int'({crcencode, fec31encode, fec32encode, pk_encode}), 0);
    rst = 1'b0;
    next();

    // tx, rx/8PSK with length clamp, EDR tx with tailer, zero-length, fec31
    run_pkt(1'b1, 4'h4, 10'd27,   1'b1, 1'b0, 216,  1, 0, 0, 6, 30, 0);
    run_pkt(1'b0, 4'hA, 10'd1023, 1'b0, 1'b0, 8168, 1, 0, 1, 2, 20, 0);
    run_pkt(1'b1, 4'h4, 10'd54,   1'b0, 1'b1, 432,  1, 0, 0, 3, 20, 12);
    run_pkt(1'b1, 4'h1, 10'd9,    1'b1, 1'b0, 0,    0, 0, 0, 6, 0, 0);
    run_pkt(1'b0, 4'h5, 10'd3,    1'b1, 1'b0, 80,   0, 1, 0, 6, 14, 0);
    run_pkt(1'b1, 4'h2, 10'd0,    1'b1, 1'b0, 144,  1, 0, 1, 6, 8, 0);

    // unsupported type
    next();
    t0 = cyc;
    pk_type = 4'h8; start_p = 1'b1;
    push_ev(t0 + 1, 3);
    next();
    start_p = 1'b0;
    check_val("busy_in_err", int'(busy), 1);
    next();
    check_val("busy_after_err", int'(busy), 0);

    // ignored restart while busy, then abort coincident with end of payload
    next();
    t0 = cyc;
    tx = 1'b1; pk_type = 4'h4; len_byte = 10'd10; packet_BRmode = 1'b1; start_p = 1'b1;
    push_ev(t0 + 1, 0); push_ev(t0 + 7, 1); push_ev(t0 + 13, 1);
    next();
    start_p = 1'b0;
    wait_until(t0 + 4);
    pk_type = 4'h2; tx = 1'b0; start_p = 1'b1;
    next();
    start_p = 1'b0;
    check_val("ignored_start_len", int'(pylenbit), 80);
    check_val("ignored_start_fec32", int'(fec32encode), 0);
    check_val("ignored_start_tx", int'(pk_encode), 1);
    wait_until(t0 + 15);
    abort_p = 1'b1; py_endp = 1'b1;
    next();
    abort_p = 1'b0; py_endp = 1'b0;
    check_val("abort_idle", int'(busy), 0);
    next();
    check_val("abort_cfg_hold", int'(pylenbit), 80);

    // reset mid-payload
    next();
    t0 = cyc;
    tx = 1'b1; pk_type = 4'h4; len_byte = 10'd27; packet_BRmode = 1'b1; start_p = 1'b1;
    push_ev(t0 + 1, 0); push_ev(t0 + 7, 1);
    next();
    start_p = 1'b0;
    wait_until(t0 + 9);
    rst = 1'b1;
    next();
    rst = 1'b0;
    check_val("midrst_outputs", int'({py_st_p, py_datvalid_p, done_p, err_p, busy}), 0);
    check_val("midrst_pylenbit", int'(pylenbit), 0);
    check_val("midrst_config", int'({crcencode, fec31encode, fec32encode, pk_encode}), 0);

    // symbol timeout: 8191 strobes at period 2, no end event
    next();
    t0 = cyc;
    tx = 1'b0; pk_type = 4'h9; len_byte = 10'd5; packet_BRmode = 1'b0; packet_DPSK = 1'b0;
    start_p = 1'b1;
    push_ev(t0 + 1, 0);
    for (int i = 0; i < 8191; i++) push_ev(t0 + 3 + 2 * i, 1);
    push_ev(t0 + 16385, 3);
    next();
    start_p = 1'b0;
    check_val("aux1_pylenbit", int'(pylenbit), 40);
    check_val("aux1_crc", int'(crcencode), 0);
    wait_until(t0 + 16385);
    check_val("busy_in_timeout_err", int'(busy), 1);
    next();
    check_val("busy_after_timeout", int'(busy), 0);

    next(); next();
    check_val("leftover_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pyseq_ctrl.md
# pyseq_ctrl

Payload sequencer and controller for the payload bit processor. It decodes the packet type and length into the processor's configuration, issues the payload start pulse, and generates the per-symbol data-valid strobe at the modulation rate from `clk_6M`. It then waits for the processor's end-of-payload pulse and, for EDR transmit, the tailer, before reporting completion. It sits between the link controller (header done / type / length) and the payload bit processor.

## Interface
Parameters:
- `TIMEOUT_SYM`, default 8191: maximum number of data-valid strobes per payload before the sequencer reports an error.

Ports:
- `clk_6M` in 1: 6 MHz system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_p` in 1: header complete, begin the payload; single-cycle pulse.
- `abort_p` in 1: abandon the current payload; single-cycle pulse.
- `tx` in 1: 1 = transmit (encode), 0 = receive (decode); latched at start.
- `pk_type` in 4: packet type; latched at start.
- `len_byte` in 10: payload length in bytes, for length-driven types; latched at start.
- `packet_BRmode` in 1: basic rate; latched at start.
- `packet_DPSK` in 1: EDR 2 Mbps when `packet_BRmode`=0; otherwise 8PSK; latched at start.
- `py_endp` in 1: transmit end of payload, from the processor.
- `dec_py_endp` in 1: receive end of payload, from the processor.
- `edrtailer_endp` in 1: EDR tailer finished.
- `py_st_p` out 1: payload start pulse.
- `py_datvalid_p` out 1: symbol-rate strobe.
- `pylenbit` out 13: payload bits, excluding CRC.
- `crcencode`, `fec31encode`, `fec32encode` out 1 each: coding configuration.
- `pk_encode` out 1: equals the latched `tx`.
- `busy` out 1: sequencer not in IDLE.
- `done_p` out 1: payload complete.
- `err_p` out 1: unsupported type or timeout.

## Operation
Packet type decode (pylenbit / crc / fec):
- 0 NULL, 1 POLL: 0 / 0 / none.
- 2 FHS: 144 / 1 / fec32.
- 3 DM1, A DM3, E DM5: L / 1 / fec32.
- 4 DH1, B DH3, F DH5: L / 1 / none.
- 5 HV1: 80 / 0 / fec31.
- 6 HV2: 160 / 0 / fec32.
- 7 HV3: 240 / 0 / none.
- 9 AUX1: L / 0 / none.
- 8, C, D: unsupported; the sequencer pulses `err_p` and returns to IDLE.

L = {min(`len_byte`, 1021), 3'b0}. Widths are zero-extended to 13 bits.

Strobe divider N is set by the latched mode: 6 for BR, 3 for DPSK, 2 for 8PSK.

FSM states:
- IDLE: on `start_p`, latch the inputs and go to ST. Unsupported type goes to ERR instead.
- ST: `py_st_p`=1 and the divider is cleared. If `pylenbit`==0, go to DONE; otherwise go to RUN.
- RUN: the divider counts 0..N-1 and wraps. `py_datvalid_p`=1 when the divider is at N-1. The symbol counter increments on each strobe. The end event is `py_endp` when `tx`=1 and `dec_py_endp` when `tx`=0.
  - On the end event with `tx` & !BR, go to TAIL.
  - On the end event otherwise, go to DONE.
  - When the symbol counter reaches `TIMEOUT_SYM`, go to ERR.
- TAIL: strobes continue. On `edrtailer_endp`, go to DONE.
- DONE: `done_p`=1, then go to IDLE.
- ERR: `err_p`=1, then go to IDLE.

Boundary conditions:
- `abort_p` in any state forces IDLE on the next edge, with no `done_p` or `err_p`. Abort wins over a simultaneous end event.
- `start_p` outside IDLE is ignored.
- Configuration outputs hold their latched values until the next accepted start.

## Timing
- Reset values: every output 0; `pylenbit` 0; state IDLE; divider 0.
- `start_p` at cycle T: configuration outputs valid from T+1, and `py_st_p` is high at T+1 only.
- First `py_datvalid_p` at T+N+1 (BR: T+7). Strobes then repeat every N cycles.
- End event at cycle E in RUN: `done_p` at E+1 and `busy` low at E+2.
- `py_datvalid_p` is never asserted in IDLE, ST, DONE or ERR.
- Reset mid-payload: at the next edge the block is in IDLE with all outputs 0.

## Structure
- Shared package holds:
  - packet type constants `PT_NULL`…`PT_DH5`;
  - FSM state enum;
  - divider constants `DIV_BR`=6, `DIV_DPSK`=3, `DIV_8PSK`=2;
  - `MAX_LEN_BYTE`=1021.
- One sub-module, `pysym_strobe`: a divider with clear, enable and an N input, producing `py_datvalid_p`.

## Test plan
- DH1, tx, BR, `len_byte`=27, `start_p` at T → `py_st_p` at T+1, `pylenbit`=216, `crcencode`=1, strobes at T+7, T+13…; `py_endp` at E → `done_p` at E+1.
- DM3, rx, 8PSK, `len_byte`=1023 → `pylenbit`=8168, `fec32encode`=1, strobes every 2 cycles; `dec_py_endp` → `done_p` with no tailer.
- 2-DH1, tx, DPSK → strobe period 3; `py_endp` → TAIL; `edrtailer_endp` 12 cycles later → `done_p` next cycle.
- POLL → `py_st_p`, then `done_p` one cycle later, with no strobes.
- Type 8 → `err_p` at T+1 and no `py_st_p`. In a separate run, withhold `py_endp` → `err_p` after 8191 strobes.
- `abort_p` during RUN simultaneous with `py_endp` → IDLE, no `done_p`. `start_p` asserted while busy → ignored.
